// File: rtl/data_memory_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the shared
// single-port data memory. The arbiter is the slave side.
interface data_memory_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] rdata_a;
  logic              done_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic [DATA_W-1:0] rdata_b;
  logic              done_b;
  logic              err_b;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read_write;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    output rdata_a, done_a,
    input  req_b, we_b, addr_b, wdata_b,
    output rdata_b, done_b, err_b,
    output mem_address, mem_write_data, mem_read_write,
    input  mem_read_data,
    output busy
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    input  rdata_a, done_a,
    output req_b, we_b, addr_b, wdata_b,
    input  rdata_b, done_b, err_b,
    input  mem_address, mem_write_data, mem_read_write,
    output mem_read_data,
    input  busy
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter sharing a single-port data memory between the CPU
// datapath (port A) and the debug/loader (port B). One access per three
// cycles: IDLE (grant) -> ACCESS (memory cycle) -> RESP (done pulse).
// Port B writes below PROT_LIMIT complete with err_b and never reach memory.
module data_memory_arbiter #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                FIXED_PRIO = 0,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = 8'd16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  logic   grant_b;
  logic   last_grant_b;
  logic   we_l;
  logic   reject_l;
  logic   pick_b;

  // Choose which port wins this IDLE cycle (only used when a request is high)
  always_comb begin
    pick_b = 1'b0;
    if (bus.req_a && bus.req_b) begin
      if (FIXED_PRIO != 0) begin
        pick_b = 1'b0;
      end else begin
        pick_b = ~last_grant_b;
      end
    end else begin
      pick_b = bus.req_b;
    end
  end

  // Memory write strobe comes straight from state so reset kills it at once
  assign bus.mem_read_write = (state == ACCESS) && we_l && !reject_l;
  assign bus.busy           = (state != IDLE);

  // Sequencer: grant and latch in IDLE, capture/complete in ACCESS, pulse in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      grant_b            <= 1'b0;
      last_grant_b       <= 1'b1;
      we_l               <= 1'b0;
      reject_l           <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
      bus.rdata_a        <= '0;
      bus.rdata_b        <= '0;
      bus.done_a         <= 1'b0;
      bus.done_b         <= 1'b0;
      bus.err_b          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            grant_b            <= pick_b;
            we_l               <= pick_b ? bus.we_b    : bus.we_a;
            bus.mem_address    <= pick_b ? bus.addr_b  : bus.addr_a;
            bus.mem_write_data <= pick_b ? bus.wdata_b : bus.wdata_a;
            reject_l           <= pick_b && bus.we_b && (bus.addr_b < PROT_LIMIT);
            state              <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_l) begin
            if (grant_b) begin
              bus.rdata_b <= bus.mem_read_data;
            end else begin
              bus.rdata_a <= bus.mem_read_data;
            end
          end
          bus.done_a   <= ~grant_b;
          bus.done_b   <= grant_b;
          bus.err_b    <= reject_l;
          last_grant_b <= grant_b;
          state        <= RESP;
        end
        RESP: begin
          bus.done_a <= 1'b0;
          bus.done_b <= 1'b0;
          bus.err_b  <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench: two arbiters (round-robin and fixed priority) each with a
// small behavioural memory, driven with hand-computed access sequences.
module tb_data_memory_arbiter;

  logic clk;
  logic rst_n;
  int   num_compared;
  int   num_mismatched;

  data_memory_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  data_memory_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

  data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0), .PROT_LIMIT(8'd16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1), .PROT_LIMIT(8'd16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  // 100 MHz-style clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memories: synchronous write, combinational read
  always @(posedge clk) begin
    if (bus0.mem_read_write) mem0[bus0.mem_address] <= bus0.mem_write_data;
    if (bus1.mem_read_write) mem1[bus1.mem_address] <= bus1.mem_write_data;
  end
  assign bus0.mem_read_data = mem0[bus0.mem_address];
  assign bus1.mem_read_data = mem1[bus1.mem_address];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit port_b, input bit req, input bit we,
                               input logic [7:0] addr, input logic [7:0] wdata);
    if (port_b) begin
      bus0.req_b = req; bus0.we_b = we; bus0.addr_b = addr; bus0.wdata_b = wdata;
    end else begin
      bus0.req_a = req; bus0.we_a = we; bus0.addr_a = addr; bus0.wdata_a = wdata;
    end
  endtask

  // One complete access on dut0, started with the arbiter in IDLE
  task automatic runAccess(input string tag, input bit port_b, input bit we,
                           input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] exp_rdata, input bit exp_err);
    applyStimulus(port_b, 1'b1, we, addr, wdata);
    @(posedge clk); #1;
    checkOutput({tag, "_busy"},  32'(bus0.busy), 32'd1);
    checkOutput({tag, "_mrw"},   32'(bus0.mem_read_write), 32'(we & ~exp_err));
    checkOutput({tag, "_maddr"}, 32'(bus0.mem_address), 32'(addr));
    checkOutput({tag, "_early"}, 32'(port_b ? bus0.done_b : bus0.done_a), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_done"},  32'(port_b ? bus0.done_b : bus0.done_a), 32'd1);
    checkOutput({tag, "_other"}, 32'(port_b ? bus0.done_a : bus0.done_b), 32'd0);
    checkOutput({tag, "_err"},   32'(bus0.err_b), 32'(exp_err));
    checkOutput({tag, "_mrw2"},  32'(bus0.mem_read_write), 32'd0);
    if (!we) checkOutput({tag, "_rdata"}, 32'(port_b ? bus0.rdata_b : bus0.rdata_a), 32'(exp_rdata));
    applyStimulus(port_b, 1'b0, 1'b0, addr, wdata);
    @(posedge clk); #1;
    checkOutput({tag, "_pulse"}, 32'(port_b ? bus0.done_b : bus0.done_a), 32'd0);
    checkOutput({tag, "_idle"},  32'(bus0.busy), 32'd0);
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[8'h30] = 8'h11; mem0[8'h31] = 8'h22; mem0[8'h20] = 8'h33;
    mem1[8'h30] = 8'h44; mem1[8'h31] = 8'h55;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    bus1.req_a = 1'b0; bus1.we_a = 1'b0; bus1.addr_a = 8'h30; bus1.wdata_a = 8'h00;
    bus1.req_b = 1'b0; bus1.we_b = 1'b0; bus1.addr_b = 8'h31; bus1.wdata_b = 8'h00;

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy",  32'(bus0.busy), 32'd0);
    checkOutput("rst_mrw",   32'(bus0.mem_read_write), 32'd0);
    checkOutput("rst_maddr", 32'(bus0.mem_address), 32'd0);
    checkOutput("rst_done",  32'({bus0.done_a, bus0.done_b, bus0.err_b}), 32'd0);
    checkOutput("rst_rdata", 32'({bus0.rdata_a, bus0.rdata_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin tie: A, B, A, B with dones three cycles apart
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h31, 8'h00);
    for (int i = 0; i < 4; i++) begin
      repeat ((i == 0) ? 1 : 2) @(posedge clk);
      #1;
      checkOutput($sformatf("rr%0d_gap", i), 32'({bus0.done_a, bus0.done_b}), 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("rr%0d_done_a", i), 32'(bus0.done_a), 32'((i % 2) == 0));
      checkOutput($sformatf("rr%0d_done_b", i), 32'(bus0.done_b), 32'((i % 2) == 1));
    end
    checkOutput("rr_rdata_a", 32'(bus0.rdata_a), 32'h11);
    checkOutput("rr_rdata_b", 32'(bus0.rdata_b), 32'h22);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;

    // Port A write then read back
    runAccess("a_wr64", 1'b0, 1'b1, 8'h64, 8'hA5, 8'h00, 1'b0);
    runAccess("a_rd64", 1'b0, 1'b0, 8'h64, 8'h00, 8'hA5, 1'b0);

    // Address change after the grant edge must not redirect the access
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h64, 8'h5A);
    @(posedge clk); #1;
    bus0.addr_a = 8'h65;
    #1;
    checkOutput("hold_maddr", 32'(bus0.mem_address), 32'h64);
    @(posedge clk); #1;
    checkOutput("hold_done", 32'(bus0.done_a), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h65, 8'h00);
    @(posedge clk); #1;
    runAccess("hold_rd64", 1'b0, 1'b0, 8'h64, 8'h00, 8'h5A, 1'b0);
    runAccess("hold_rd65", 1'b0, 1'b0, 8'h65, 8'h00, 8'h00, 1'b0);

    // Write protection of the low region against port B
    runAccess("a_wr0f",   1'b0, 1'b1, 8'h0F, 8'h77, 8'h00, 1'b0);
    runAccess("b_wr0f",   1'b1, 1'b1, 8'h0F, 8'h05, 8'h00, 1'b1);
    runAccess("a_rd0f",   1'b0, 1'b0, 8'h0F, 8'h00, 8'h77, 1'b0);
    runAccess("b_wr10",   1'b1, 1'b1, 8'h10, 8'h99, 8'h00, 1'b0);
    runAccess("a_rd10",   1'b0, 1'b0, 8'h10, 8'h00, 8'h99, 1'b0);
    runAccess("b_rd0f",   1'b1, 1'b0, 8'h0F, 8'h00, 8'h77, 1'b0);

    // Fixed priority: A starves B until A lets go
    bus1.req_a = 1'b1;
    bus1.req_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat ((i == 0) ? 2 : 3) @(posedge clk);
      #1;
      checkOutput($sformatf("fp%0d_done_a", i), 32'(bus1.done_a), 32'd1);
      checkOutput($sformatf("fp%0d_done_b", i), 32'(bus1.done_b), 32'd0);
    end
    checkOutput("fp_rdata_a", 32'(bus1.rdata_a), 32'h44);
    bus1.req_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("fp_b_done",  32'(bus1.done_b), 32'd1);
    checkOutput("fp_b_nota",  32'(bus1.done_a), 32'd0);
    checkOutput("fp_rdata_b", 32'(bus1.rdata_b), 32'h55);
    bus1.req_b = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a write access
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h20, 8'hEE);
    @(posedge clk); #1;
    checkOutput("ar_mrw_on", 32'(bus0.mem_read_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_mrw_off", 32'(bus0.mem_read_write), 32'd0);
    checkOutput("ar_busy",    32'(bus0.busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    checkOutput("ar_no_done", 32'(bus0.done_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ar_tie_a",   32'(bus0.done_a), 32'd1);
    checkOutput("ar_tie_b",   32'(bus0.done_b), 32'd0);
    checkOutput("ar_rdata20", 32'(bus0.rdata_a), 32'h33);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ar_then_b",  32'(bus0.done_b), 32'd1);
    checkOutput("ar_rdata10", 32'(bus0.rdata_b), 32'h99);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
